// File: rtl/dram_frame_writer_pkg.sv
// Shared definitions for the DRAM frame writer: packed Camera Link word
// layout, CL packer state codes, MIG command encodings and the writer FSM
// state type.
package dram_frame_writer_pkg;

    // Packed CL word geometry
    localparam int WORD_W       = 256;
    localparam int MASK_W       = WORD_W / 8;
    localparam int PIX_W        = 240;

    // n_full: upstream FIFO fill indication carried in the top bits
    localparam int N_FULL_SIZE  = 3;
    localparam int N_FULL_LSB   = WORD_W - N_FULL_SIZE;   // 253

    // Per-channel headers
    localparam int CL0_HDR_W    = 5;
    localparam int CL0_HDR_LSB  = 248;
    localparam int CL1_HDR_W    = 4;
    localparam int CL1_HDR_LSB  = 244;
    localparam int CL2_HDR_W    = 4;
    localparam int CL2_HDR_LSB  = 240;

    // Flag positions inside the headers
    localparam int NEW_FRAME_BIT = CL0_HDR_LSB + 4;       // 252
    localparam int FVAL_BIT      = CL2_HDR_LSB + 1;       // 241
    localparam int LVAL_BIT      = CL2_HDR_LSB;           // 240

    // Camera Link packer state codes (as seen in the CL headers)
    typedef enum logic [1:0] {
        CL0       = 2'd0,
        CL1       = 2'd1,
        CL2       = 2'd2,
        INTERLINE = 2'd3
    } cl_state_t;

    // MIG user interface command encodings
    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    // Writer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FULL  = 2'd3
    } wr_state_t;

    // A word starts a frame when the CL0 new-frame flag and fval are both set
    function automatic logic is_frame_start(input logic [WORD_W-1:0] w);
        return w[NEW_FRAME_BIT] & w[FVAL_BIT];
    endfunction

    // Any non-zero n_full means the upstream FIFO dropped data
    function automatic logic has_overflow(input logic [WORD_W-1:0] w);
        return |w[WORD_W-1:N_FULL_LSB];
    endfunction

endpackage

// File: rtl/dram_frame_writer_mig_wr_handshake.sv
// MIG write handshake: raises app_en and app_wdf_wren together on start and
// retires each independently as the MIG accepts it. done pulses in the cycle
// the second (or both) acceptances happen.
module mig_wr_handshake (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic app_rdy,
    input  logic app_wdf_rdy,
    output logic app_en,
    output logic app_wdf_wren,
    output logic done
);

    logic cmd_done;
    logic data_done;
    logic in_flight;
    logic cmd_ok;
    logic data_ok;

    // Accepted already, or being accepted on this edge
    assign cmd_ok  = cmd_done  | (app_en       & app_rdy);
    assign data_ok = data_done | (app_wdf_wren & app_wdf_rdy);
    assign done    = in_flight & cmd_ok & data_ok;

    // Independent accept tracking for the command and data channels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            in_flight    <= 1'b0;
        end else if (start) begin
            app_en       <= 1'b1;
            app_wdf_wren <= 1'b1;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            in_flight    <= 1'b1;
        end else begin
            if (app_en && app_rdy) begin
                app_en   <= 1'b0;
                cmd_done <= 1'b1;
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                app_wdf_wren <= 1'b0;
                data_done    <= 1'b1;
            end
            if (done)
                in_flight <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_frame_writer.sv
// DRAM frame writer: drains packed CL words from the DRAM write FIFO into the
// MIG, one single-beat write per word at sequential addresses, and reports
// frame count, sticky overflow and fill status.
// Build option DRAM_FRAME_WRITER_WRAP_EN: when defined the address wraps from
// END_ADDR back to BASE_ADDR (ring buffer) and mem_full is tied 0; otherwise
// the writer parks in FULL once END_ADDR has been written.
module dram_frame_writer
    import dram_frame_writer_pkg::*;
#(
    parameter int                 ADDR_W       = 28,
    parameter int                 ADDR_STEP    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
    parameter logic [ADDR_W-1:0]  END_ADDR     = 28'h7FF_FFF8,
    parameter int                 N_FRAME_SIZE = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    fifo_empty,
    output logic                    fifo_rden,
    input  logic [255:0]            fifo_dout,
    input  logic                    app_rdy,
    output logic                    app_en,
    output logic [2:0]              app_cmd,
    output logic [ADDR_W-1:0]       app_addr,
    input  logic                    app_wdf_rdy,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [255:0]            app_wdf_data,
    output logic [31:0]             app_wdf_mask,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [N_FRAME_SIZE-1:0] n_frame,
    output logic                    overflow,
    output logic                    mem_full,
    output logic                    busy
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    wr_state_t state;
    logic      enable_d;
    logic      hs_start;
    logic      hs_done;
    logic      last_word;
    logic      more_ok;

    assign app_cmd      = MIG_CMD_WRITE;
    assign app_wdf_mask = '0;
    assign app_wdf_end  = app_wdf_wren;
    assign busy         = (state != IDLE);
    assign hs_start     = (state == FETCH);

    // The word in flight sits at the last address of the buffer
    assign last_word = (app_addr == END_ADDR);

`ifdef DRAM_FRAME_WRITER_WRAP_EN
    assign more_ok  = 1'b1;
    assign mem_full = 1'b0;
`else
    assign more_ok  = !last_word;
`endif

    mig_wr_handshake u_hs (
        .clk          (clk),
        .reset        (reset),
        .start        (hs_start),
        .app_rdy      (app_rdy),
        .app_wdf_rdy  (app_wdf_rdy),
        .app_en       (app_en),
        .app_wdf_wren (app_wdf_wren),
        .done         (hs_done)
    );

    // Pop strobe: must see the live fifo_empty, so it is decided in the same
    // cycle the FSM leaves IDLE or retires a word; dout is then valid in FETCH
    always_comb begin
        fifo_rden = 1'b0;
        if (!reset && enable && !fifo_empty) begin
            if (state == IDLE)
                fifo_rden = 1'b1;
            else if (state == ISSUE && hs_done && more_ok)
                fifo_rden = 1'b1;
        end
    end

    // Writer FSM with status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            enable_d     <= 1'b0;
            app_addr     <= '0;
            app_wdf_data <= '0;
            wr_addr      <= BASE_ADDR;
            n_frame      <= '0;
            overflow     <= 1'b0;
`ifndef DRAM_FRAME_WRITER_WRAP_EN
            mem_full     <= 1'b0;
`endif
        end else begin
            enable_d <= enable;
            case (state)
                IDLE: begin
                    // A fresh enable starts a new capture from the base
                    if (enable && !enable_d) begin
                        n_frame  <= '0;
                        overflow <= 1'b0;
                        wr_addr  <= BASE_ADDR;
`ifndef DRAM_FRAME_WRITER_WRAP_EN
                        mem_full <= 1'b0;
`endif
                    end
                    if (fifo_rden)
                        state <= FETCH;
                end
                FETCH: begin
                    app_wdf_data <= fifo_dout;
                    app_addr     <= wr_addr;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    if (hs_done) begin
`ifdef DRAM_FRAME_WRITER_WRAP_EN
                        wr_addr <= last_word ? BASE_ADDR : wr_addr + STEP;
`else
                        wr_addr <= wr_addr + STEP;
`endif
                        if (is_frame_start(app_wdf_data) && (n_frame != '1))
                            n_frame <= n_frame + 1'b1;
                        if (has_overflow(app_wdf_data))
                            overflow <= 1'b1;
                        if (fifo_rden)
                            state <= FETCH;
`ifndef DRAM_FRAME_WRITER_WRAP_EN
                        else if (!more_ok) begin
                            state    <= FULL;
                            mem_full <= 1'b1;
                        end
`endif
                        else
                            state <= IDLE;
                    end
                end
                FULL: begin
                    // Parked until software drops enable
                    if (!enable)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_frame_writer.sv
// Bench for dram_frame_writer: FIFO model feeding the DUT, scoreboard queues
// of expected MIG addresses/data checked by a monitor, directed scenarios
// checking status outputs.
module tb_dram_frame_writer;

    localparam int              AW    = 28;
    localparam logic [AW-1:0]   END_A = 28'h38;   // 8 words: 0..56

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           fifo_empty;
    logic           fifo_rden;
    logic [255:0]   fifo_dout = '0;
    logic           app_rdy;
    logic           app_en;
    logic [2:0]     app_cmd;
    logic [AW-1:0]  app_addr;
    logic           app_wdf_rdy;
    logic           app_wdf_wren;
    logic           app_wdf_end;
    logic [255:0]   app_wdf_data;
    logic [31:0]    app_wdf_mask;
    logic [AW-1:0]  wr_addr;
    logic [19:0]    n_frame;
    logic           overflow;
    logic           mem_full;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    // FIFO model storage and counters
    logic [255:0]   fmem [0:63];
    int             wr_cnt    = 0;
    int             rd_cnt    = 0;
    int             rden_cnt  = 0;
    int             cyc       = 0;
    int             rden_cyc [0:63];
    logic           flush     = 1'b0;

    logic [AW-1:0]  exp_addr_q [$];
    logic [255:0]   exp_data_q [$];

    assign fifo_empty = (wr_cnt == rd_cnt);

    dram_frame_writer #(.END_ADDR(END_A)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rden    (fifo_rden),
        .fifo_dout    (fifo_dout),
        .app_rdy      (app_rdy),
        .app_en       (app_en),
        .app_cmd      (app_cmd),
        .app_addr     (app_addr),
        .app_wdf_rdy  (app_wdf_rdy),
        .app_wdf_wren (app_wdf_wren),
        .app_wdf_end  (app_wdf_end),
        .app_wdf_data (app_wdf_data),
        .app_wdf_mask (app_wdf_mask),
        .wr_addr      (wr_addr),
        .n_frame      (n_frame),
        .overflow     (overflow),
        .mem_full     (mem_full),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Standard FIFO: dout valid the cycle after rden
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) begin
            rd_cnt <= wr_cnt;
        end else if (fifo_rden) begin
            check("rden_when_empty", fifo_empty, 1'b0);
            if (!fifo_empty) begin
                fifo_dout <= fmem[rd_cnt % 64];
                rd_cnt    <= rd_cnt + 1;
            end
            rden_cyc[rden_cnt % 64] <= cyc;
            rden_cnt <= rden_cnt + 1;
        end
    end

    // Monitor: pop the scoreboard on every MIG accept
    always @(negedge clk) begin
        if (!reset) begin
            if (app_en && app_rdy) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd_unexpected: got addr %0h expected none", app_addr);
                end else begin
                    check("cmd_addr", app_addr, exp_addr_q.pop_front());
                    check("cmd_code", app_cmd, 3'b000);
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (exp_data_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL data_unexpected: got %0h expected none", app_wdf_data);
                end else begin
                    check("wdf_data", app_wdf_data, exp_data_q.pop_front());
                    check("wdf_end", app_wdf_end, 1'b1);
                    check("wdf_mask", app_wdf_mask, 32'h0);
                end
            end
        end
    end

    function automatic logic [255:0] mk(input logic [2:0] nf, input logic [4:0] h0,
                                         input logic [3:0] h2, input logic [31:0] tag);
        logic [255:0] w;
        w = '0;
        w[255:253] = nf;
        w[252:248] = h0;
        w[247:244] = 4'h3;
        w[243:240] = h2;
        w[239:208] = ~tag;
        w[31:0]    = tag;
        return w;
    endfunction

    task automatic push(input logic [255:0] w, input bit expect_it, input logic [AW-1:0] a);
        fmem[wr_cnt % 64] = w;
        wr_cnt++;
        if (expect_it) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(w);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        if (busy) begin
            checks++; failures++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        reset       = 1'b1;
        enable      = 1'b0;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        tick(3);

        // Reset state
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_wdata", app_wdf_data, 0);
        check("rst_app_addr", app_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_n_frame", n_frame, 0);
        check("rst_flags", {overflow, mem_full, busy, fifo_rden}, 4'b0000);
        reset = 1'b0;
        tick(2);

        // 1: four preloaded words, MIG always ready
        for (int i = 0; i < 4; i++)
            push(mk(3'b000, 5'h00, 4'h0, 32'h1000 + i), 1'b1, AW'(8 * i));
        base = rden_cnt;
        enable = 1'b1;
        tick(2);
        wait_idle(60, "t1_idle");
        check("t1_wr_addr", wr_addr, 32);
        check("t1_rden_cnt", rden_cnt - base, 4);
        for (int i = 0; i < 3; i++)
            check("t1_rden_spacing", rden_cyc[base + i + 1] - rden_cyc[base + i], 2);
        check("t1_sb_empty", exp_addr_q.size() + exp_data_q.size(), 0);
        check("t1_status", {n_frame, overflow, mem_full}, 22'h0);
        enable = 1'b0;
        tick(2);

        // 2: command held off, data accepted first
        push(mk(3'b000, 5'h00, 4'h1, 32'h2000), 1'b1, 28'h0);
        app_rdy = 1'b0;
        enable  = 1'b1;
        tick(3);
        check("t2_app_en_held", app_en, 1'b1);
        check("t2_wren_dropped", app_wdf_wren, 1'b0);
        check("t2_addr_hold", wr_addr, 0);
        tick(2);
        app_rdy = 1'b1;
        tick(1);
        wait_idle(20, "t2_idle");
        check("t2_wr_addr", wr_addr, 8);
        check("t2_sb_empty", exp_addr_q.size() + exp_data_q.size(), 0);
        enable = 1'b0;
        tick(2);

        // 3: frame start and overflow flags
        push(mk(3'b000, 5'h10, 4'h0, 32'h3000), 1'b1, 28'h0);   // new-frame without fval
        push(mk(3'b000, 5'h10, 4'h2, 32'h3001), 1'b1, 28'h8);   // frame start
        push(mk(3'b010, 5'h00, 4'h2, 32'h3002), 1'b1, 28'h10);  // n_full != 0
        enable = 1'b1;
        tick(2);
        wait_idle(40, "t3_idle");
        check("t3_n_frame", n_frame, 1);
        check("t3_overflow", overflow, 1'b1);
        check("t3_wr_addr", wr_addr, 24);
        enable = 1'b0;
        tick(3);
        check("t3_overflow_sticky", overflow, 1'b1);
        check("t3_n_frame_hold", n_frame, 1);
        enable = 1'b1;
        tick(2);
        check("t3_overflow_cleared", overflow, 1'b0);
        check("t3_n_frame_cleared", n_frame, 0);
        check("t3_wr_addr_base", wr_addr, 0);
        enable = 1'b0;
        tick(2);

        // 4: address exhaustion with 9 words queued, END at 56
        for (int i = 0; i < 8; i++)
            push(mk(3'b000, 5'h00, 4'h0, 32'h4000 + i), 1'b1, AW'(8 * i));
`ifdef DRAM_FRAME_WRITER_WRAP_EN
        push(mk(3'b000, 5'h00, 4'h0, 32'h4008), 1'b1, 28'h0);
`else
        push(mk(3'b000, 5'h00, 4'h0, 32'h4008), 1'b0, 28'h0);
`endif
        base = rden_cnt;
        enable = 1'b1;
        tick(30);
`ifdef DRAM_FRAME_WRITER_WRAP_EN
        check("t4_mem_full", mem_full, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_wr_addr", wr_addr, 8);
        check("t4_rden_cnt", rden_cnt - base, 9);
        check("t4_fifo_left", wr_cnt - rd_cnt, 0);
        enable = 1'b0;
        tick(2);
`else
        check("t4_mem_full", mem_full, 1'b1);
        check("t4_busy_full", busy, 1'b1);
        check("t4_wr_addr", wr_addr, 64);
        check("t4_rden_cnt", rden_cnt - base, 8);
        check("t4_fifo_left", wr_cnt - rd_cnt, 1);
        enable = 1'b0;
        tick(2);
        check("t4_exit_idle", busy, 1'b0);
        check("t4_mem_full_held", mem_full, 1'b1);
`endif
        check("t4_sb_empty", exp_addr_q.size() + exp_data_q.size(), 0);
        do_flush();

        // 5: enable dropped during ISSUE with the FIFO non-empty
        push(mk(3'b000, 5'h00, 4'h0, 32'h5000), 1'b1, 28'h0);
        push(mk(3'b000, 5'h00, 4'h0, 32'h5001), 1'b0, 28'h0);
        push(mk(3'b000, 5'h00, 4'h0, 32'h5002), 1'b0, 28'h0);
        app_rdy = 1'b0;
        base = rden_cnt;
        enable = 1'b1;
        tick(3);
        check("t5_mem_full_cleared", mem_full, 1'b0);
        check("t5_in_issue", app_en, 1'b1);
        enable = 1'b0;
        tick(2);
        app_rdy = 1'b1;
        tick(1);
        wait_idle(20, "t5_idle");
        tick(3);
        check("t5_rden_cnt", rden_cnt - base, 1);
        check("t5_fifo_left", wr_cnt - rd_cnt, 2);
        check("t5_wr_addr", wr_addr, 8);
        check("t5_busy", busy, 1'b0);
        check("t5_sb_empty", exp_addr_q.size() + exp_data_q.size(), 0);
        do_flush();

        // 6: reset in the middle of a stalled write
        push(mk(3'b000, 5'h10, 4'h2, 32'h6000), 1'b0, 28'h0);
        push(mk(3'b000, 5'h00, 4'h0, 32'h6001), 1'b0, 28'h0);
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        enable      = 1'b1;
        tick(3);
        check("t6_pre_app_en", app_en, 1'b1);
        reset = 1'b1;
        tick(1);
        check("t6_app_en", app_en, 1'b0);
        check("t6_wren", app_wdf_wren, 1'b0);
        check("t6_wdata", app_wdf_data, 0);
        check("t6_app_addr", app_addr, 0);
        check("t6_wr_addr", wr_addr, 0);
        check("t6_flags", {overflow, mem_full, busy, fifo_rden}, 4'b0000);
        enable = 1'b0;
        tick(1);
        reset       = 1'b0;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        do_flush();
        tick(2);
        check("end_sb_empty", exp_addr_q.size() + exp_data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
